rule_aggregator: RTL and testbench

Accumulation stage between the rule evaluator and the defuzzifier. It consumes one beat per fuzzy rule over a valid/ready stream. Each beat carries a firing strength w and a singleton consequent g, both Q1.15. Per N_RULES-beat frame it produces S_w = Σw and S_wg = Σround(w·g) in Q1.15, which the defuzzifier turns into G = S_wg/S_w·100 %.

---
 rtl/fuzzy_pkg.sv | 13 +
 rtl/rule_mac.sv | 22 ++
 rtl/rule_aggregator.sv | 138 +++++++++++++
 tb/tb_rule_aggregator.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fuzzy_pkg.sv
// Shared Q1.15 types and constants for the fuzzy rule evaluator, aggregator and defuzzifier.
package fuzzy_pkg;
  typedef logic [15:0] q15_t;

  localparam q15_t        Q15_ONE         = 16'h8000;
  localparam q15_t        Q15_MAX         = 16'hFFFF;
  localparam logic [31:0] Q15_HALF_LSB    = 32'h4000;
  localparam int          N_RULES_DEFAULT = 9;

  function automatic q15_t q15_clip(input q15_t x);
    return (x > Q15_ONE) ? Q15_ONE : x;
  endfunction
endpackage

// File: rtl/rule_mac.sv
// Combinational per-rule term: clip w and g to 1.0, then w*g rounded half-up back to Q1.15.
module rule_mac
  import fuzzy_pkg::*;
(
  input  q15_t i_w,
  input  q15_t i_g,
  output q15_t o_w,
  output q15_t o_term
);
  q15_t        w_w;
  q15_t        w_g;
  logic [31:0] w_prod;
  logic [31:0] w_rnd;

  assign w_w    = q15_clip(i_w);
  assign w_g    = q15_clip(i_g);
  assign w_prod = {16'h0000, w_w} * {16'h0000, w_g};
  assign w_rnd  = w_prod + Q15_HALF_LSB;
  // With both operands clipped to 0x8000 the shifted result never exceeds 0x8000.
  assign o_term = q15_t'(w_rnd >> 15);
  assign o_w    = w_w;
endmodule

// File: rtl/rule_aggregator.sv
// Sums firing strengths and weighted consequents over one rule frame and hands
// the saturated Q1.15 totals to the defuzzifier over a valid/ready handshake.
module rule_aggregator
  import fuzzy_pkg::*;
#(
  parameter int N_RULES = N_RULES_DEFAULT,
  parameter int ACC_W   = 21
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_w,
  input  logic [15:0] in_g,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] S_w,
  output logic [15:0] S_wg,
  output logic        sat,
  output logic        frame_err
);
  localparam int CNT_W = (N_RULES > 1) ? $clog2(N_RULES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_RULES - 1);
  localparam logic [ACC_W-1:0] ACC_Q15_MAX = {{(ACC_W-16){1'b0}}, Q15_MAX};

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc_w;
  logic [ACC_W-1:0] r_acc_wg;
  logic [ACC_W-1:0] w_acc_w_nxt;
  logic [ACC_W-1:0] w_acc_wg_nxt;
  logic             r_last_seen;
  q15_t             r_s_w;
  q15_t             r_s_wg;
  logic             r_sat;
  logic             r_frame_err;
  q15_t             w_mac_w;
  q15_t             w_mac_term;
  logic             w_accept;
  logic             w_final;
  logic             w_release;

  rule_mac u_mac (
    .i_w    (in_w),
    .i_g    (in_g),
    .o_w    (w_mac_w),
    .o_term (w_mac_term)
  );

  assign w_acc_w_nxt  = r_acc_w  + {{(ACC_W-16){1'b0}}, w_mac_w};
  assign w_acc_wg_nxt = r_acc_wg + {{(ACC_W-16){1'b0}}, w_mac_term};

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    w_final     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_ACC: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid && (r_cnt == CNT_LAST)) begin
          w_final     = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_release   = 1'b1;
          w_state_nxt = ST_ACC;
        end
      end
      default: w_state_nxt = ST_ACC;
    endcase
    // Abort wins over a beat or a result handshake in the same cycle.
    if (clr) begin
      w_state_nxt = ST_ACC;
      w_accept    = 1'b0;
      w_final     = 1'b0;
      w_release   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_acc_w     <= '0;
      r_acc_wg    <= '0;
      r_last_seen <= 1'b0;
    end else if (clr || w_release) begin
      r_cnt       <= '0;
      r_acc_w     <= '0;
      r_acc_wg    <= '0;
      r_last_seen <= 1'b0;
    end else if (w_accept && !w_final) begin
      r_cnt       <= r_cnt + 1'b1;
      r_acc_w     <= w_acc_w_nxt;
      r_acc_wg    <= w_acc_wg_nxt;
      r_last_seen <= r_last_seen | in_last;
    end
  end

  // Result registers survive acceptance and clr; only the next completed frame replaces them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_w       <= '0;
      r_s_wg      <= '0;
      r_sat       <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (w_final) begin
      r_s_w       <= (w_acc_w_nxt  > ACC_Q15_MAX) ? Q15_MAX : q15_t'(w_acc_w_nxt);
      r_s_wg      <= (w_acc_wg_nxt > ACC_Q15_MAX) ? Q15_MAX : q15_t'(w_acc_wg_nxt);
      r_sat       <= (w_acc_w_nxt > ACC_Q15_MAX) || (w_acc_wg_nxt > ACC_Q15_MAX);
      r_frame_err <= r_last_seen || !in_last;
    end
  end

  assign S_w       = r_s_w;
  assign S_wg      = r_s_wg;
  assign sat       = r_sat;
  assign frame_err = r_frame_err;
endmodule

// File: tb/tb_rule_aggregator.sv
// Frame-level bench for rule_aggregator: directed and random frames against a plain-arithmetic model.
module tb_rule_aggregator;
  localparam int N = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_w = '0;
  logic [15:0] in_g = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] S_w;
  logic [15:0] S_wg;
  logic        sat;
  logic        frame_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] fw [N];
  logic [15:0] fg [N];
  bit          fl [N];
  bit          rnd_gaps = 1'b0;

  logic [15:0] e_sw, e_swg;
  bit          e_sat, e_err;

  rule_aggregator #(.N_RULES(N), .ACC_W(21)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_w      (in_w),
    .in_g      (in_g),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S_w       (S_w),
    .S_wg      (S_wg),
    .sat       (sat),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: clip, multiply, round half up, sum in wide integers, then saturate.
  task automatic model();
    longint sw = 0, swg = 0, w, g;
    e_err = !fl[N-1];
    for (int i = 0; i < N; i++) begin
      w = (fw[i] > 16'h8000) ? 32768 : longint'(fw[i]);
      g = (fg[i] > 16'h8000) ? 32768 : longint'(fg[i]);
      sw  += w;
      swg += (w * g + 16384) / 32768;
      if (fl[i] && i < N - 1) e_err = 1'b1;
    end
    e_sat = (sw > 65535) || (swg > 65535);
    e_sw  = (sw  > 65535) ? 16'hFFFF : 16'(sw);
    e_swg = (swg > 65535) ? 16'hFFFF : 16'(swg);
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin
      fw[i] = '0;
      fg[i] = '0;
      fl[i] = (i == N - 1);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic beat(input logic [15:0] w, input logic [15:0] g, input bit last);
    int n = 0;
    in_w = w; in_g = g; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("beat_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input int hold, input bit accept);
    logic [15:0] keep_sw;
    model();
    for (int i = 0; i < N; i++) begin
      beat(fw[i], fg[i], fl[i]);
      if (i < N - 1) begin
        chk("ovalid_early", 32'(out_valid), 32'd0);
        if (rnd_gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    chk("ovalid_lat", 32'(out_valid), 32'd1);
    chk("iready_hold", 32'(in_ready), 32'd0);
    chk("S_w", 32'(S_w), 32'(e_sw));
    chk("S_wg", 32'(S_wg), 32'(e_swg));
    chk("sat", 32'(sat), 32'(e_sat));
    chk("frame_err", 32'(frame_err), 32'(e_err));
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1; in_w = 16'h8000; in_g = 16'h8000;
      @(posedge clk);
      #1;
      chk("bp_ovalid", 32'(out_valid), 32'd1);
      chk("bp_iready", 32'(in_ready), 32'd0);
      chk("bp_S_w", 32'(S_w), 32'(e_sw));
      chk("bp_S_wg", 32'(S_wg), 32'(e_swg));
    end
    in_valid = 1'b0;
    if (accept) begin
      keep_sw = S_w;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("acc_ovalid", 32'(out_valid), 32'd0);
      chk("acc_iready", 32'(in_ready), 32'd1);
      chk("acc_S_w_kept", 32'(S_w), 32'(keep_sw));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_iready", 32'(in_ready), 32'd1);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_S_w", 32'(S_w), 32'd0);
    chk("rst_S_wg", 32'(S_wg), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_iready", 32'(in_ready), 32'd1);

    // single rule at beat 4
    clear_frame();
    fw[3] = 16'h8000; fg[3] = 16'h4000;
    run_frame(0, 1'b1);
    chk("d1_S_w", 32'(S_w), 32'h8000);
    chk("d1_S_wg", 32'(S_wg), 32'h4000);

    // two half-strength rules with opposite consequents
    clear_frame();
    fw[0] = 16'h4000; fg[0] = 16'h8000;
    fw[5] = 16'h4000; fg[5] = 16'h0000;
    run_frame(0, 1'b1);
    chk("d2_S_wg", 32'(S_wg), 32'h4000);

    // rounding boundaries and input clip
    clear_frame();
    fw[2] = 16'h0001; fg[2] = 16'h4000;
    run_frame(0, 1'b1);
    chk("rnd_up", 32'(S_wg), 32'h0001);
    clear_frame();
    fw[2] = 16'h0001; fg[2] = 16'h3FFF;
    run_frame(0, 1'b1);
    chk("rnd_down", 32'(S_wg), 32'h0000);
    clear_frame();
    fw[6] = 16'h9000; fg[6] = 16'h4000;
    run_frame(0, 1'b1);
    chk("clip_S_w", 32'(S_w), 32'h8000);

    // saturation, then backpressure with in_valid held high
    clear_frame();
    for (int i = 0; i < N; i++) begin fw[i] = 16'h8000; fg[i] = 16'h8000; end
    run_frame(5, 1'b1);
    chk("sat_flag", 32'(sat), 32'd1);
    clear_frame();
    fw[0] = 16'h1234; fg[0] = 16'h5678;
    run_frame(0, 1'b1);
    chk("post_bp_sat", 32'(sat), 32'd0);

    // early in_last
    clear_frame();
    fl[2] = 1'b1;
    fw[8] = 16'h0100; fg[8] = 16'h8000;
    run_frame(0, 1'b1);
    chk("early_last", 32'(frame_err), 32'd1);

    // clr mid-frame, with a beat offered in the same cycle
    for (int i = 0; i < 5; i++) beat(16'h8000, 16'h8000, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_w = 16'h8000; in_g = 16'h8000;
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_ovalid", 32'(out_valid), 32'd0);
    chk("clr_S_w_kept", 32'(S_w), 32'(e_sw));
    clear_frame();
    fw[4] = 16'h2000; fg[4] = 16'h6000;
    run_frame(0, 1'b1);

    // async reset during HOLD
    clear_frame();
    fw[1] = 16'h7000; fg[1] = 16'h7000;
    fl[8] = 1'b0;
    run_frame(0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ovalid", 32'(out_valid), 32'd0);
    chk("arst_S_w", 32'(S_w), 32'd0);
    chk("arst_S_wg", 32'(S_wg), 32'd0);
    chk("arst_ferr", 32'(frame_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_iready", 32'(in_ready), 32'd1);

    // random frames
    rnd_gaps = 1'b1;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 5))
          0:       fw[i] = 16'h0000;
          1:       fw[i] = 16'($urandom_range(16'h8000, 16'hFFFF));
          default: fw[i] = 16'($urandom_range(0, 16'h2000));
        endcase
        fg[i] = 16'($urandom_range(0, 16'h9000));
        fl[i] = (i == N - 1);
      end
      if ($urandom_range(0, 3) == 0) fl[$urandom_range(0, N - 1)] ^= 1'b1;
      run_frame(int'($urandom_range(0, 3)), 1'b1);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
